if_fetch_unit: RTL

- Producer side of the IF/ID pipeline register. Owns the fetch PC and issues requests to the synchronous instruction memory.
- Buffers returned instructions in a small skid queue so that IF_ID_reg_write_en stalls never lose an in-flight instruction.
- Presents PC_out_IF, instruction_out_IF and a valid flag to IF/ID.
- Applies redirects from EX (jump or YAGS conflict) and predicted-taken redirects from the YAGS predictor in IF.

---
 rtl/if_fetch_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues synchronous instruction-memory reads and
// buffers returning words in a small skid queue ahead of the IF/ID register.
module if_fetch_unit #(
    parameter int                size      = 32,
    parameter int                PC_size   = 10,
    parameter logic [size-1:0]   RESET_PC  = '0,
    parameter int                BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               IF_ID_reg_write_en,
    input  logic               redirect_EX,
    input  logic [size-1:0]    redirect_target_EX,
    input  logic               pred_taken_IF,
    input  logic [size-1:0]    pred_target_IF,
    output logic               imem_req,
    output logic [PC_size-1:0] imem_addr,
    input  logic [size-1:0]    imem_rdata,
    output logic               fetch_valid_IF,
    output logic [size-1:0]    PC_out_IF,
    output logic [size-1:0]    instruction_out_IF
);

    localparam int                PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int                CNT_W   = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W:0]    DEPTH_V = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [size-1:0]   NOP     = 32'h0000_0013;

    logic [size-1:0]  pc_f;
    logic [size-1:0]  q_pc    [BUF_DEPTH];
    logic [size-1:0]  q_instr [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             inflight;
    logic [size-1:0]  inflight_pc;

    logic             head_q, bypass, has_head, pop, pop_q, pred_flush;
    logic             resp_write, seq_issue;
    logic [size-1:0]  head_pc, head_instr, req_pc;
    logic [CNT_W:0]   occupancy;

    // Head comes from the queue when it holds anything, otherwise straight off the memory bus.
    always_comb begin
        head_q     = (count != '0);
        bypass     = (count == '0) && inflight;
        has_head   = head_q || bypass;
        head_pc    = head_q ? q_pc[rd_ptr]    : inflight_pc;
        head_instr = head_q ? q_instr[rd_ptr] : imem_rdata;

        fetch_valid_IF     = !reset && has_head && !redirect_EX;
        PC_out_IF          = fetch_valid_IF ? head_pc    : '0;
        instruction_out_IF = fetch_valid_IF ? head_instr : NOP;

        pop        = fetch_valid_IF && IF_ID_reg_write_en;
        pop_q      = pop && head_q;
        pred_flush = pop && pred_taken_IF;
        resp_write = inflight && !(bypass && pop);

        // Slots that will be committed after this edge, counting the word still on the bus.
        occupancy  = (CNT_W + 1)'(count) + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
        seq_issue  = occupancy < DEPTH_V;

        if (redirect_EX)
            req_pc = {redirect_target_EX[size-1:2], 2'b00};
        else if (pred_flush)
            req_pc = {pred_target_IF[size-1:2], 2'b00};
        else
            req_pc = pc_f;

        imem_req  = !reset && (redirect_EX || pred_flush || seq_issue);
        imem_addr = req_pc[PC_size+1:2];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f        <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_EX || pred_flush) begin
            // Everything younger than the consumed head (if any) is dropped.
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            inflight    <= 1'b1;
            inflight_pc <= req_pc;
            pc_f        <= req_pc + size'(4);
        end else begin
            if (resp_write)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_q)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count + CNT_W'(resp_write) - CNT_W'(pop_q);
            inflight <= seq_issue;
            if (seq_issue) begin
                inflight_pc <= pc_f;
                pc_f        <= pc_f + size'(4);
            end
        end
    end

    // Queue storage needs no reset; count and pointers qualify every read.
    always_ff @(posedge clk) begin
        if (!reset && !redirect_EX && !pred_flush && resp_write) begin
            q_pc[wr_ptr]    <= inflight_pc;
            q_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule
